// File: rtl/divider_seq32_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and counter sizing.
package div_pkg;
  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } div_state_e;
endpackage

// File: rtl/divider_seq32_if.sv
// Request/response bundle for divider_seq32: valid/ready in, valid/ready out.
interface divider_seq32_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) ();
  logic             in_valid;
  logic             in_ready;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output in_valid, is_signed, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, is_signed, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/divider_seq32_sub.sv
// Ripple carry-chain adder built from full-adder cells, and the trial subtractor on top of it.
module fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module adder_cc #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         ci_i,
  output logic [W-1:0] sum_o,
  output logic         co_o
);
  logic [W:0] c;
  assign c[0] = ci_i;
  for (genvar i = 0; i < W; i++) begin : g_bit
    fa_cell u_fa (.a_i(a_i[i]), .b_i(b_i[i]), .c_i(c[i]), .s_o(sum_o[i]), .c_o(c[i+1]));
  end
  assign co_o = c[W];
endmodule

module subtractor_w #(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] diff_o,
  output logic         borrow_o
);
  logic co;
  // a - b == a + ~b + 1; a clear carry-out means the subtraction borrowed
  adder_cc #(.W(W)) u_add (.a_i(a_i), .b_i(~b_i), .ci_i(1'b1), .sum_o(diff_o), .co_o(co));
  assign borrow_o = ~co;
endmodule

// File: rtl/divider_seq32.sv
// Multi-cycle restoring divider, signed/unsigned, with zero-divisor and overflow fast paths.
module divider_seq32
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic       clk,
  input  logic       rst_n,
  divider_seq32_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_q, quo_q, dsr_q;
  logic             neg_quo_q, neg_rem_q, dbz_q;

  logic             a_neg, b_neg, ovf;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   part, diff;
  logic             borrow;
  logic             unused_diff_msb;

  assign a_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign b_neg = bus.is_signed & bus.divisor[WIDTH-1];
  assign a_mag = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag = b_neg ? -bus.divisor  : bus.divisor;
  assign ovf   = bus.is_signed && (bus.dividend == MOST_NEG) && (bus.divisor == '1);

  // quo_q doubles as the dividend shifter: its MSB feeds the partial remainder
  assign part = {acc_q, quo_q[WIDTH-1]};

  subtractor_w #(.W(WIDTH+1)) u_sub (
    .a_i(part), .b_i({1'b0, dsr_q}), .diff_o(diff), .borrow_o(borrow)
  );
  assign unused_diff_msb = diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          cnt_q <= '0;
          dbz_q <= 1'b0;
          if (bus.divisor == '0) begin
            acc_q   <= bus.dividend;
            quo_q   <= '1;
            dbz_q   <= 1'b1;
            state_q <= DONE;
          end else if (ovf) begin
            acc_q   <= '0;
            quo_q   <= bus.dividend;
            state_q <= DONE;
          end else begin
            acc_q     <= '0;
            quo_q     <= a_mag;
            dsr_q     <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            state_q   <= CALC;
          end
        end
        CALC: begin
          acc_q <= borrow ? part[WIDTH-1:0] : diff[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], ~borrow};
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) state_q <= FIXUP;
        end
        FIXUP: begin
          if (neg_quo_q) quo_q <= -quo_q;
          if (neg_rem_q) acc_q <= -acc_q;
          state_q <= DONE;
        end
        DONE: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quo_q;
  assign bus.remainder   = acc_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_divider_seq32.sv
// Directed and random checks of divider_seq32 against an arithmetic reference model.
module tb_divider_seq32;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divider_seq32_if #(.WIDTH(W)) bus ();
  divider_seq32 #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output bit dz, output int lat);
    longint sa, sb;
    dz = 1'b0;
    lat = 34;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = 32'd0; lat = 1;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Called at a negedge; returns at the negedge just after the accept edge.
  task automatic send(input bit s, input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    bus.is_signed = s; bus.dividend = a; bus.divisor = b; bus.in_valid = 1'b1;
    while (!bus.in_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("in_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
    bus.is_signed = 1'($urandom_range(0, 1));
  endtask

  // Counts edges from the accept edge (inclusive) until out_valid is seen.
  task automatic wait_res(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!bus.out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic check_res(input string tag, input bit s, input logic [31:0] a,
                           input logic [31:0] b, input int lat);
    logic [31:0] q, r; bit dz; int el;
    model(s, a, b, q, r, dz, el);
    chk({tag, "_quo"}, bus.quotient, q);
    chk({tag, "_rem"}, bus.remainder, r);
    chk({tag, "_dbz"}, bus.div_by_zero, dz);
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_rdy"}, bus.in_ready, 1'b0);
  endtask

  task automatic release_res();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("hs_out_valid", bus.out_valid, 1'b0);
    chk("hs_in_ready", bus.in_ready, 1'b1);
  endtask

  task automatic op(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
    int lat;
    send(s, a, b);
    wait_res(lat);
    check_res(tag, s, a, b, lat);
    release_res();
  endtask

  initial begin
    int lat;
    logic [31:0] hq, hr, ra, rb;
    logic hdz;
    bit rs;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.is_signed = 1'b0;
    bus.dividend = '0;   bus.divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_quo", bus.quotient, 32'd0);
    chk("rst_rem", bus.remainder, 32'd0);
    chk("rst_dbz", bus.div_by_zero, 1'b0);
    rst_n = 1'b1;

    op("u100_7",   1'b0, 32'd100, 32'd7);
    op("s_m7_2",   1'b1, 32'hFFFF_FFF9, 32'd2);
    op("u_ff_10",  1'b0, 32'hFFFF_FFFF, 32'h10);
    op("u5_0",     1'b0, 32'd5, 32'd0);
    op("s5_0",     1'b1, 32'd5, 32'd0);
    op("s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    op("u_mn_m1",  1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    op("s_7_m2",   1'b1, 32'd7, 32'hFFFF_FFFE);
    op("s_m8_m3",  1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD);

    // result must hold while the consumer stalls
    send(1'b0, 32'd1000, 32'd33);
    wait_res(lat);
    check_res("hold", 1'b0, 32'd1000, 32'd33, lat);
    hq = bus.quotient; hr = bus.remainder; hdz = bus.div_by_zero;
    repeat (5) begin
      @(negedge clk);
      chk("hold_quo", bus.quotient, hq);
      chk("hold_rem", bus.remainder, hr);
      chk("hold_dbz", bus.div_by_zero, hdz);
      chk("hold_valid", bus.out_valid, 1'b1);
      chk("hold_rdy", bus.in_ready, 1'b0);
    end
    release_res();

    // back-to-back: next request waiting during the result handshake
    send(1'b1, 32'(-100), 32'd7);
    wait_res(lat);
    check_res("b2b1", 1'b1, 32'(-100), 32'd7, lat);
    bus.out_ready = 1'b1;
    bus.is_signed = 1'b0; bus.dividend = 32'd12345; bus.divisor = 32'd77; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("b2b_idle_rdy", bus.in_ready, 1'b1);
    chk("b2b_idle_vld", bus.out_valid, 1'b0);
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("b2b_accepted", bus.in_ready, 1'b0);
    bus.in_valid = 1'b0; bus.dividend = $urandom; bus.divisor = $urandom;
    wait_res(lat);
    check_res("b2b2", 1'b0, 32'd12345, 32'd77, lat);
    release_res();

    // reset mid-CALC abandons the operation
    send(1'b0, 32'hDEAD_BEEF, 32'd13);
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", bus.out_valid, 1'b0);
    chk("mrst_in_ready", bus.in_ready, 1'b1);
    chk("mrst_quo", bus.quotient, 32'd0);
    @(negedge clk);
    chk("mrst_out_valid2", bus.out_valid, 1'b0);
    chk("mrst_in_ready2", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    op("rst_9_3", 1'b0, 32'd9, 32'd3);

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        3: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        4: rb = rb >> $urandom_range(0, 31);
        default: ;
      endcase
      op("rnd", rs, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider_seq32.md
DIVIDER_SEQ32 -- requirements
Module: divider_seq32

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; SHALL be even and at least 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled at accept.
REQ-007 dividend  input  WIDTH  numerator; sampled at accept.
REQ-008 divisor  input  WIDTH  denominator; sampled at accept.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 quotient  output  WIDTH  result quotient.
REQ-012 remainder  output  WIDTH  result remainder.
REQ-013 div_by_zero  output  1  result came from a zero divisor.

Function
REQ-014 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; operands and is_signed latched then, later input changes ignored.
REQ-015 States: IDLE, CALC, FIXUP, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE->CALC on accept with normal operands; IDLE->DONE on accept with divisor=0 or signed overflow (dividend=most-negative, divisor=-1, is_signed=1).
REQ-017 CALC SHALL run exactly WIDTH cycles of radix-2 restoring division on magnitudes: shift partial remainder left by one, bring in next dividend bit (MSB first), trial-subtract divisor magnitude, keep the difference and set quotient bit 1 when there is no borrow, else restore and set 0.
REQ-018 CALC->FIXUP after iteration WIDTH-1; FIXUP SHALL negate quotient if operand signs differ and negate remainder if dividend negative (signed mode only), then ->DONE.
REQ-019 Normal latency: out_valid rises WIDTH+2 rising edges after the accept edge (34 at WIDTH=32); fast-path latency: 1 edge.
REQ-020 Divisor=0: quotient=all ones, remainder=dividend, div_by_zero=1, in both modes.
REQ-021 Signed overflow: quotient=dividend (most-negative), remainder=0, div_by_zero=0.
REQ-022 Signed results SHALL truncate toward zero; remainder sign SHALL equal dividend sign.
REQ-023 DONE: quotient, remainder, div_by_zero SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 DONE->IDLE on edge with out_ready=1; no new request is accepted on that same edge (in_ready=0 in DONE).
REQ-025 Iteration counter SHALL be ceil(log2(WIDTH)) bits and reset to 0 on every accept.

Reset
REQ-026 While rst_n=0: state=IDLE, counter=0, quotient=0, remainder=0, div_by_zero=0, out_valid=0, in_ready=1.
REQ-027 Reset asserted mid-CALC, FIXUP or DONE SHALL abandon the operation immediately with no result delivered; first accept is possible on the first edge after rst_n rises.

Structure
REQ-028 Shared package div_pkg SHALL hold the state encoding (IDLE=0, CALC=1, FIXUP=2, DONE=3) and the counter-width constant.
REQ-029 Trial subtraction SHALL be a sub-module subtractor_w (WIDTH+1 bits) built on the team's carry-chain adder: op2 inverted, carry-in 1, borrow = inverted carry-out.
REQ-030 Magnitude/negate logic and the state machine SHALL reside in divider_seq32 itself.

Verification (WIDTH=32)
REQ-031 Unsigned 100/7 -> quotient 14, remainder 2, div_by_zero 0, out_valid exactly 34 edges after accept.
REQ-032 Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; unsigned 0xFFFFFFFF/0x10 -> 0x0FFFFFFF rem 0xF.
REQ-033 5/0 in either mode -> quotient 0xFFFFFFFF, remainder 5, div_by_zero 1, out_valid 1 edge after accept.
REQ-034 Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, 1-edge latency.
REQ-035 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready 0; back-to-back requests with out_ready=1 -> second accept exactly 1 edge after first result's handshake.
REQ-036 rst_n pulsed low at CALC iteration 10 -> out_valid stays 0, in_ready 1 during reset, next request 9/3 returns 3 rem 0.
